// File: rtl/mcp300x_scan_sampler.sv
// Multi-channel SPI scan sampler for MCP3004/3008-class ADCs.
// Round-robins enabled channels, oversamples each one and emits averaged
// results through a one-deep valid/ready output register.
module mcp300x_scan_sampler #(
  parameter int unsigned CLK_DIV    = 38,
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned ADC_BITS   = 10,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned CS_HIGH_HP = 2
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            enable,
  input  logic [NUM_CH-1:0]                               ch_mask,
  input  logic [NUM_CH-1:0]                               diff_mask,
  output logic                                            ad_clk,
  output logic                                            cs,
  output logic                                            din,
  input  logic                                            dout,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic [ADC_BITS-1:0]                             out_data,
  output logic                                            busy,
  output logic                                            overrun,
  output logic                                            null_err
);

  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);
  localparam int unsigned FRAME_P  = 7 + ADC_BITS;
  localparam int unsigned PER_W    = $clog2(FRAME_P + 1);
  localparam int unsigned HOLD_W   = (CS_HIGH_HP > 1) ? $clog2(CS_HIGH_HP) : 1;
  localparam int unsigned AVG_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ACC_W    = ADC_BITS + AVG_LOG2;
  localparam int unsigned AVG_LAST = (1 << AVG_LOG2) - 1;

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  state_t              state, state_d;
  logic [DIV_W-1:0]    div_cnt, div_d;
  logic                hi_phase, hi_d;
  logic [PER_W-1:0]    period, per_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic [CH_W-1:0]     cur_ch, ch_d, ptr, ptr_d, pick, ch_sel;
  logic                sgl, sgl_d;
  logic [AVG_W-1:0]    avg_cnt, avg_d;
  logic [ACC_W-1:0]    acc, acc_d, sum;
  logic [ADC_BITS-1:0] shreg, shreg_d, result;
  logic                done, done_d;
  logic                dout_s1, dout_s2;
  logic                cs_d, adc_d, din_d, busy_d, ov_d, ovr_d, nerr_d;
  logic [CH_W-1:0]     och_d;
  logic [ADC_BITS-1:0] odat_d;
  logic                half_end, emit, found;
  int                  idx;

  assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign result   = sum[ACC_W-1:AVG_LOG2];

  // Command bit driven on din during a given SHIFT period
  function automatic logic cmd_bit(input logic [PER_W-1:0] p, input logic s,
                                   input logic [2:0] c);
    case (p)
      PER_W'(1): cmd_bit = 1'b1;
      PER_W'(2): cmd_bit = s;
      PER_W'(3): cmd_bit = c[2];
      PER_W'(4): cmd_bit = c[1];
      PER_W'(5): cmd_bit = c[0];
      default:   cmd_bit = 1'b0;
    endcase
  endfunction

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Datapath, synchroniser and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;  hi_phase <= 1'b0; period <= '0;   hold_cnt <= '0;
      cur_ch  <= '0;  ptr      <= '0;   sgl    <= 1'b0; avg_cnt  <= '0;
      acc     <= '0;  shreg    <= '0;   done   <= 1'b0;
      dout_s1 <= 1'b0; dout_s2 <= 1'b0;
      cs <= 1'b1; ad_clk <= 1'b0; din <= 1'b0; busy <= 1'b0;
      out_valid <= 1'b0; out_ch <= '0; out_data <= '0;
      overrun <= 1'b0; null_err <= 1'b0;
    end else begin
      div_cnt <= div_d;  hi_phase <= hi_d;  period <= per_d;  hold_cnt <= hold_d;
      cur_ch  <= ch_d;   ptr      <= ptr_d; sgl    <= sgl_d;  avg_cnt  <= avg_d;
      acc     <= acc_d;  shreg    <= shreg_d; done <= done_d;
      dout_s1 <= dout;   dout_s2  <= dout_s1;
      cs <= cs_d; ad_clk <= adc_d; din <= din_d; busy <= busy_d;
      out_valid <= ov_d; out_ch <= och_d; out_data <= odat_d;
      overrun <= ovr_d; null_err <= nerr_d;
    end
  end

  // Next-state, channel selection, averaging and output handshake
  always_comb begin
    state_d = state;
    div_d   = half_end ? '0 : div_cnt + DIV_W'(1);
    hi_d    = hi_phase; per_d = period; hold_d = hold_cnt;
    ch_d    = cur_ch;   ptr_d = ptr;    sgl_d  = sgl;
    avg_d   = avg_cnt;  acc_d = acc;    shreg_d = shreg; done_d = 1'b0;
    cs_d    = cs; adc_d = ad_clk; din_d = din; busy_d = busy;
    ov_d    = out_valid; och_d = out_ch; odat_d = out_data;
    ovr_d   = overrun;   nerr_d = null_err;
    sum     = acc + ACC_W'(shreg);
    emit    = 1'b0;

    // Next enabled channel at or above the pointer, wrapping around
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = int'(ptr) + i;
      if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
      if (!found && ch_mask[CH_W'(idx)]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
    // An averaging group in progress stays on its channel
    ch_sel = (avg_cnt != '0) ? cur_ch : pick;

    case (state)
      IDLE: begin
        div_d = '0;
        if (enable && (ch_mask != '0)) begin
          state_d = CS_SETUP;
          ch_d    = ch_sel;
          sgl_d   = ~diff_mask[ch_sel];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          adc_d   = 1'b0;
          din_d   = 1'b0;
        end else begin
          acc_d = '0;
          avg_d = '0;
        end
      end
      CS_SETUP: begin
        if (half_end) begin
          state_d = SHIFT;
          per_d   = PER_W'(1);
          hi_d    = 1'b0;
          din_d   = cmd_bit(PER_W'(1), sgl, 3'(cur_ch));
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (!hi_phase) begin
            hi_d  = 1'b1;
            adc_d = 1'b1;
          end else begin
            if (period == PER_W'(7) && dout_s2) nerr_d = 1'b1;
            if (period >= PER_W'(8)) shreg_d = {shreg[ADC_BITS-2:0], dout_s2};
            adc_d = 1'b0;
            if (period == PER_W'(FRAME_P)) begin
              state_d = CS_HOLD;
              cs_d    = 1'b1;
              busy_d  = 1'b0;
              hold_d  = '0;
              done_d  = 1'b1;
            end else begin
              per_d = period + PER_W'(1);
              hi_d  = 1'b0;
              din_d = cmd_bit(period + PER_W'(1), sgl, 3'(cur_ch));
            end
          end
        end
      end
      CS_HOLD: begin
        if (half_end) begin
          if (hold_cnt == HOLD_W'(CS_HIGH_HP - 1)) state_d = IDLE;
          else                                    hold_d  = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Fold the finished conversion into the averaging group
    if (done) begin
      if (avg_cnt == AVG_W'(AVG_LAST)) begin
        emit  = 1'b1;
        acc_d = '0;
        avg_d = '0;
        ptr_d = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + CH_W'(1);
      end else begin
        acc_d = sum;
        avg_d = avg_cnt + AVG_W'(1);
      end
    end

    // One-deep output register: a held, unaccepted result wins over a new one
    if (out_valid && out_ready) ov_d = 1'b0;
    if (emit) begin
      if (!out_valid || out_ready) begin
        ov_d   = 1'b1;
        och_d  = cur_ch;
        odat_d = result;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mcp300x_scan_sampler.sv
// Bench for mcp300x_scan_sampler: instance 0 without averaging, instance 1
// averaging groups of four; each has a behavioural MCP3008 model on its pins.
module tb_mcp300x_scan_sampler;

  localparam int unsigned CLK_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       null_force = 1'b0;
  logic [9:0] ch_val  [8];
  logic [9:0] avg_seq [8];

  logic       en  [2];
  logic [7:0] chm [2];
  logic [7:0] dfm [2];
  logic       rdy [2];
  logic       adc [2], csw [2], dinw [2], doutw [2];
  logic       ovw [2], busyw [2], ovrw [2], nerr [2];
  logic [2:0] och [2];
  logic [9:0] odat [2];

  for (genvar g = 0; g < 2; g++) begin : gm
    mcp300x_scan_sampler #(
      .CLK_DIV(CLK_DIV), .NUM_CH(8), .ADC_BITS(10), .AVG_LOG2(g * 2), .CS_HIGH_HP(2)
    ) dut (
      .clk(clk), .rst_n(rst_n), .enable(en[g]), .ch_mask(chm[g]), .diff_mask(dfm[g]),
      .ad_clk(adc[g]), .cs(csw[g]), .din(dinw[g]), .dout(doutw[g]),
      .out_valid(ovw[g]), .out_ready(rdy[g]), .out_ch(och[g]), .out_data(odat[g]),
      .busy(busyw[g]), .overrun(ovrw[g]), .null_err(nerr[g])
    );

    int          rcnt = 0;
    int          fcnt = 0;
    int          last_rcnt = 0;
    int          busy_bad = 0;
    logic [17:0] dlog = '0;
    logic [17:0] last_dlog = '0;
    logic [9:0]  val = '0;
    logic [2:0]  fch = '0;
    logic        fsgl = 1'b0;
    logic [12:0] rq [$];
    logic [3:0]  flog [$];
    int          per;
    logic        dv;
    logic        nullf;

    assign nullf = (g == 0) ? null_force : 1'b0;

    // ADC side: count AD_CLK rising edges, log DIN, decode the command after D0
    always @(posedge adc[g] or negedge csw[g]) begin
      if (!adc[g]) begin
        rcnt = 0;
        dlog = '0;
      end else if (!csw[g]) begin
        rcnt = rcnt + 1;
        if (rcnt <= 17) dlog[5'(rcnt)] = dinw[g];
        if (rcnt == 5) begin
          fsgl = dlog[2];
          fch  = {dlog[3], dlog[4], dlog[5]};
          val  = (g == 0) ? ch_val[fch] : avg_seq[fcnt % 8];
          fcnt = fcnt + 1;
        end
      end
    end

    // DOUT presents the bit of the current period from its falling edge on
    always_comb begin
      per = adc[g] ? rcnt : rcnt + 1;
      dv  = 1'b0;
      if (per == 7) dv = nullf;
      else if (per >= 8 && per <= 17) dv = val[4'(17 - per)];
    end
    assign doutw[g] = dv;

    // Record completed frames
    always @(posedge csw[g]) begin
      last_rcnt = rcnt;
      last_dlog = dlog;
      if (rcnt == 17) flog.push_back({fsgl, fch});
    end

    // Collect transfers and watch busy against cs
    always @(negedge clk) begin
      if (ovw[g] && rdy[g]) rq.push_back({och[g], odat[g]});
      if (busyw[g] !== ~csw[g]) busy_bad = busy_bad + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rq_size(input int g);
    return (g == 0) ? gm[0].rq.size() : gm[1].rq.size();
  endfunction

  task automatic wait_res(input int g, input int n, input int budget);
    int c = 0;
    while (rq_size(g) < n && c < budget) begin
      step(1);
      c++;
    end
    checks++;
    if (rq_size(g) < n) begin
      errors++;
      $display("FAIL wait_res inst%0d: have %0d results, need %0d", g, rq_size(g), n);
    end
  endtask

  task automatic wait_cs(input int g, input logic lvl, input int budget);
    int c = 0;
    while (csw[g] !== lvl && c < budget) begin
      step(1);
      c++;
    end
    checks++;
    if (csw[g] !== lvl) begin
      errors++;
      $display("FAIL wait_cs inst%0d: cs=%b, need %b", g, csw[g], lvl);
    end
  endtask

  task automatic go_idle(input int g);
    en[g] = 1'b0;
    wait_cs(g, 1'b1, 400);
    step(20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_reset();
    step(3);
    checks++; if (csw[0] !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", csw[0]); end
    checks++; if (adc[0] !== 1'b0) begin errors++; $display("FAIL reset_adclk: got %b want 0", adc[0]); end
    checks++; if (dinw[0] !== 1'b0) begin errors++; $display("FAIL reset_din: got %b want 0", dinw[0]); end
    checks++; if (ovw[0] !== 1'b0 || busyw[0] !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b%b want 00", ovw[0], busyw[0]); end
    checks++; if (ovrw[0] !== 1'b0 || nerr[0] !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b%b want 00", ovrw[0], nerr[0]); end
    checks++; if (och[0] !== 3'd0 || odat[0] !== 10'd0) begin errors++; $display("FAIL reset_out: got ch=%0d data=%h want 0/0", och[0], odat[0]); end
    rst_n = 1'b1;
    step(5);
    checks++; if (csw[0] !== 1'b1 || csw[1] !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got cs=%b%b want 11", csw[0], csw[1]); end
  endtask

  task automatic test_single();
    int base = gm[0].rq.size();
    int fb   = gm[0].flog.size();
    logic [4:0] hdr;
    ch_val[3] = 10'h2A5;
    chm[0] = 8'h08; dfm[0] = 8'h00; rdy[0] = 1'b1;
    en[0] = 1'b1;
    wait_cs(0, 1'b0, 50);
    en[0] = 1'b0;
    wait_res(0, base + 1, 400);
    go_idle(0);
    hdr = {gm[0].last_dlog[1], gm[0].last_dlog[2], gm[0].last_dlog[3], gm[0].last_dlog[4], gm[0].last_dlog[5]};
    checks++; if (hdr !== 5'b11011) begin errors++; $display("FAIL single_cmd: got %b want 11011", hdr); end
    checks++; if (gm[0].last_dlog[17:6] !== 12'h000) begin errors++; $display("FAIL single_din_tail: got %h want 000", gm[0].last_dlog[17:6]); end
    checks++; if (gm[0].last_rcnt != 17) begin errors++; $display("FAIL single_periods: got %0d want 17", gm[0].last_rcnt); end
    checks++; if (gm[0].flog.size() != fb + 1) begin errors++; $display("FAIL single_frames: got %0d want %0d", gm[0].flog.size() - fb, 1); end
    if (gm[0].rq.size() > base) begin
      checks++;
      if (gm[0].rq[base] !== {3'd3, 10'h2A5}) begin errors++; $display("FAIL single_result: got %h want %h", gm[0].rq[base], {3'd3, 10'h2A5}); end
    end
  endtask

  task automatic test_scan();
    logic [2:0] ord [5];
    int base, fb;
    ord[0] = 3'd0; ord[1] = 3'd2; ord[2] = 3'd7; ord[3] = 3'd0; ord[4] = 3'd2;
    do_reset();
    for (int i = 0; i < 8; i++) ch_val[i] = 10'($urandom);
    base = gm[0].rq.size();
    fb   = gm[0].flog.size();
    chm[0] = 8'b1000_0101; dfm[0] = 8'h04; rdy[0] = 1'b1;
    en[0] = 1'b1;
    wait_res(0, base + 5, 1200);
    go_idle(0);
    for (int i = 0; i < 5; i++) begin
      if (gm[0].rq.size() > base + i) begin
        checks++;
        if (gm[0].rq[base + i] !== {ord[i], ch_val[ord[i]]}) begin
          errors++; $display("FAIL scan_result[%0d]: got %h want %h", i, gm[0].rq[base + i], {ord[i], ch_val[ord[i]]});
        end
      end
      if (gm[0].flog.size() > fb + i) begin
        checks++;
        if (gm[0].flog[fb + i] !== {~dfm[0][ord[i]], ord[i]}) begin
          errors++; $display("FAIL scan_cmd[%0d]: got %h want %h", i, gm[0].flog[fb + i], {~dfm[0][ord[i]], ord[i]});
        end
      end
    end
  endtask

  task automatic test_avg();
    int s;
    logic [9:0] exp1;
    avg_seq[0] = 10'd100; avg_seq[1] = 10'd101; avg_seq[2] = 10'd102; avg_seq[3] = 10'd104;
    for (int i = 4; i < 8; i++) avg_seq[i] = 10'($urandom);
    s = int'(avg_seq[4]) + int'(avg_seq[5]) + int'(avg_seq[6]) + int'(avg_seq[7]);
    exp1 = 10'(s / 4);
    chm[1] = 8'h20; dfm[1] = 8'h00; rdy[1] = 1'b1;
    en[1] = 1'b1;
    wait_res(1, 1, 1000);
    checks++; if (gm[1].fcnt != 4) begin errors++; $display("FAIL avg_frames: got %0d want 4", gm[1].fcnt); end
    wait_res(1, 2, 1000);
    en[1] = 1'b0;
    wait_cs(1, 1'b1, 400);
    step(200);
    checks++; if (gm[1].rq.size() != 2) begin errors++; $display("FAIL avg_count: got %0d want 2", gm[1].rq.size()); end
    if (gm[1].rq.size() >= 2) begin
      checks++; if (gm[1].rq[0] !== {3'd5, 10'd101}) begin errors++; $display("FAIL avg_fixed: got %h want %h", gm[1].rq[0], {3'd5, 10'd101}); end
      checks++; if (gm[1].rq[1] !== {3'd5, exp1}) begin errors++; $display("FAIL avg_random: got %h want %h", gm[1].rq[1], {3'd5, exp1}); end
    end
  endtask

  task automatic test_backpressure();
    int base = gm[0].rq.size();
    int c;
    logic [9:0] a, b;
    a = 10'($urandom);
    b = a ^ 10'h3FF;
    ch_val[1] = a;
    checks++; if (ovrw[0] !== 1'b0) begin errors++; $display("FAIL bp_pre_overrun: got %b want 0", ovrw[0]); end
    chm[0] = 8'h02; rdy[0] = 1'b0;
    en[0] = 1'b1;
    c = 0;
    while (ovw[0] !== 1'b1 && c < 400) begin step(1); c++; end
    ch_val[1] = b;
    c = 0;
    while (ovrw[0] !== 1'b1 && c < 400) begin step(1); c++; end
    checks++; if (ovrw[0] !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b want 1", ovrw[0]); end
    go_idle(0);
    checks++; if (ovw[0] !== 1'b1 || och[0] !== 3'd1 || odat[0] !== a) begin
      errors++; $display("FAIL bp_held: got v=%b ch=%0d data=%h want 1/1/%h", ovw[0], och[0], odat[0], a);
    end
    checks++; if (gm[0].rq.size() != base) begin errors++; $display("FAIL bp_no_transfer: got %0d want 0", gm[0].rq.size() - base); end
    rdy[0] = 1'b1;
    step(2);
    checks++; if (gm[0].rq.size() != base + 1) begin errors++; $display("FAIL bp_release_count: got %0d want 1", gm[0].rq.size() - base); end
    if (gm[0].rq.size() > base) begin
      checks++; if (gm[0].rq[base] !== {3'd1, a}) begin errors++; $display("FAIL bp_release_data: got %h want %h", gm[0].rq[base], {3'd1, a}); end
    end
    checks++; if (ovw[0] !== 1'b0 || ovrw[0] !== 1'b1) begin errors++; $display("FAIL bp_after: got v=%b ovr=%b want 0/1", ovw[0], ovrw[0]); end
  endtask

  task automatic test_null();
    int base = gm[0].rq.size();
    logic [9:0] v;
    v = 10'($urandom);
    ch_val[4] = v;
    checks++; if (nerr[0] !== 1'b0) begin errors++; $display("FAIL null_pre: got %b want 0", nerr[0]); end
    null_force = 1'b1;
    chm[0] = 8'h10; rdy[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      en[0] = 1'b1;
      wait_cs(0, 1'b0, 50);
      en[0] = 1'b0;
      wait_res(0, base + k + 1, 400);
      go_idle(0);
      checks++; if (nerr[0] !== 1'b1) begin errors++; $display("FAIL null_sticky[%0d]: got %b want 1", k, nerr[0]); end
      if (gm[0].rq.size() > base + k) begin
        checks++; if (gm[0].rq[base + k] !== {3'd4, v}) begin errors++; $display("FAIL null_result[%0d]: got %h want %h", k, gm[0].rq[base + k], {3'd4, v}); end
      end
      null_force = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int base = gm[0].rq.size();
    int base2, fb, c;
    chm[0] = 8'h24; rdy[0] = 1'b0;
    en[0] = 1'b1;
    c = 0;
    while (ovw[0] !== 1'b1 && c < 400) begin step(1); c++; end
    c = 0;
    while (!(gm[0].rcnt == 9 && adc[0] === 1'b0 && csw[0] === 1'b0) && c < 400) begin step(1); c++; end
    checks++; if (csw[0] !== 1'b0 || gm[0].rcnt != 9) begin errors++; $display("FAIL mid_reach: got cs=%b period=%0d want 0/10", csw[0], gm[0].rcnt + 1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (csw[0] !== 1'b1 || adc[0] !== 1'b0) begin errors++; $display("FAIL mid_async: got cs=%b ad_clk=%b want 1/0", csw[0], adc[0]); end
    checks++; if (ovw[0] !== 1'b0 || busyw[0] !== 1'b0) begin errors++; $display("FAIL mid_clear: got v=%b busy=%b want 0/0", ovw[0], busyw[0]); end
    rdy[0] = 1'b1;
    step(3);
    base2 = gm[0].rq.size();
    fb    = gm[0].flog.size();
    checks++; if (base2 != base) begin errors++; $display("FAIL mid_no_partial: got %0d want 0", base2 - base); end
    rst_n = 1'b1;
    wait_res(0, base2 + 1, 400);
    go_idle(0);
    if (gm[0].rq.size() > base2) begin
      checks++; if (gm[0].rq[base2] !== {3'd2, ch_val[2]}) begin errors++; $display("FAIL mid_restart: got %h want %h", gm[0].rq[base2], {3'd2, ch_val[2]}); end
    end
    if (gm[0].flog.size() > fb) begin
      checks++; if (gm[0].flog[fb] !== {~dfm[0][2], 3'd2}) begin errors++; $display("FAIL mid_first_frame: got %h want %h", gm[0].flog[fb], {~dfm[0][2], 3'd2}); end
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      en[g] = 1'b0; chm[g] = 8'h00; dfm[g] = 8'h00; rdy[g] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      ch_val[i]  = 10'd0;
      avg_seq[i] = 10'd0;
    end
    test_reset();
    test_single();
    test_scan();
    test_avg();
    test_backpressure();
    test_null();
    test_reset_mid();
    checks++;
    if (gm[0].busy_bad != 0 || gm[1].busy_bad != 0) begin
      errors++; $display("FAIL busy_vs_cs: got %0d/%0d bad samples want 0", gm[0].busy_bad, gm[1].busy_bad);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
